// File: rtl/cva6_lu_model_if.sv
// cva6_lu_model_if: handshake and bus signals between the load-unit model and its environment.
// Signal names keep the load unit's own _i/_o direction suffixes so both sides read the same.
interface cva6_lu_model_if #(
  parameter int PC_W = 8
) ();

  logic [31:0]     load_instr_i;
  logic            load_valid_i;
  logic            load_ready_o;
  logic [11:0]     page_offset_o;
  logic            page_offset_matches_i;
  logic            load_req_o;
  logic            load_gnt_i;
  logic            load_rvalid_i;
  logic            load_done_o;
  logic [PC_W-1:0] load_done_pc_o;

  // load unit side
  modport slave (
    input  load_instr_i,
    input  load_valid_i,
    output load_ready_o,
    output page_offset_o,
    input  page_offset_matches_i,
    output load_req_o,
    input  load_gnt_i,
    input  load_rvalid_i,
    output load_done_o,
    output load_done_pc_o
  );

  // producer / store unit / memory side
  modport master (
    output load_instr_i,
    output load_valid_i,
    input  load_ready_o,
    input  page_offset_o,
    output page_offset_matches_i,
    input  load_req_o,
    output load_gnt_i,
    output load_rvalid_i,
    input  load_done_o,
    input  load_done_pc_o
  );

endinterface

// File: rtl/cva6_lu_model.sv
// cva6_lu_model: abstract in-order load unit for the CVA6 equivalence bench.
// Loads are queued, checked against pending stores by page offset, issued with a
// req/gnt/rvalid handshake and retired in order with a sequence tag.
// Optional feature: define LU_STALL_CNT_EN to add the saturating alias-stall counter
// on port stall_cnt_o.
//
//  state | meaning
//  IDLE  | waiting for a valid load at the queue head
//  CHECK | head offset presented to the store unit; holds while a store aliases it
//  REQ   | memory request raised for the head load
//  WAIT  | request granted; waiting for data, then retire the head
module cva6_lu_model #(
  parameter int LQ_DEPTH = 2,
  parameter int LQ_PTR_W = 1,
  parameter int PC_W     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  cva6_lu_model_if.slave         lu
`ifdef LU_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [LQ_DEPTH-1:0]   valid_q;
  logic [11:0]           offset_q [LQ_DEPTH];
  logic [PC_W-1:0]       pc_q     [LQ_DEPTH];
  logic [LQ_PTR_W-1:0]   head_q, tail_q;
  logic [PC_W-1:0]       pc_ctr_q;
  logic                  done_q;
  logic [PC_W-1:0]       done_pc_q;

  logic                  load_ready;
  logic                  head_valid;
  logic                  enq;
  logic                  retire;

  // Only the page offset influences behaviour; the rest of the word is carried by the producer.
  logic [19:0]           unused_instr_hi;
  assign unused_instr_hi = lu.load_instr_i[31:12];

  assign load_ready = !valid_q[tail_q];
  assign head_valid = valid_q[head_q];
  assign enq        = lu.load_valid_i && load_ready;
  assign retire     = (state_q == S_WAIT) && lu.load_rvalid_i;

  assign lu.load_ready_o   = load_ready;
  assign lu.page_offset_o  = head_valid ? offset_q[head_q] : 12'h000;
  assign lu.load_req_o     = (state_q == S_REQ);
  assign lu.load_done_o    = done_q;
  assign lu.load_done_pc_o = done_pc_q;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; gnt outside REQ and rvalid outside WAIT have no effect
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (head_valid)                    state_d = S_CHECK;
      S_CHECK: if (!lu.page_offset_matches_i)     state_d = S_REQ;
      S_REQ:   if (lu.load_gnt_i)                 state_d = S_WAIT;
      S_WAIT:  if (lu.load_rvalid_i)              state_d = S_IDLE;
      default:                                    state_d = S_IDLE;
    endcase
  end

  // Queue control: enqueue at tail and retire at head can both happen in one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      pc_ctr_q <= '0;
    end else begin
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + LQ_PTR_W'(1);
        pc_ctr_q        <= pc_ctr_q + PC_W'(1);
      end
      if (retire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + LQ_PTR_W'(1);
      end
    end
  end

  // Queue payload; only meaningful while the matching valid bit is set, so no reset
  always_ff @(posedge clk_i) begin
    if (enq) begin
      offset_q[tail_q] <= lu.load_instr_i[11:0];
      pc_q[tail_q]     <= pc_ctr_q;
    end
  end

  // Retire pulse and sticky tag of the last retired load
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q    <= 1'b0;
      done_pc_q <= '0;
    end else begin
      done_q <= retire;
      if (retire) begin
        done_pc_q <= pc_q[head_q];
      end
    end
  end

`ifdef LU_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles spent held in CHECK by an aliasing store
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_CHECK) && lu.page_offset_matches_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cva6_lu_model.sv
// tb_cva6_lu_model: self-checking bench for cva6_lu_model.
// Expected retire tags are queued when a load is accepted and compared as retires are logged.
module tb_cva6_lu_model;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cva6_lu_model_if #(.PC_W(8)) lu_if ();

`ifdef LU_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  cva6_lu_model #(.LQ_DEPTH(2), .LQ_PTR_W(1), .PC_W(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .lu     (lu_if)
`ifdef LU_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  // store-unit model: one pending store, aliasing on the double-word of the offset
  logic        store_pending = 1'b0;
  logic [11:0] store_off = 12'h000;
  assign lu_if.page_offset_matches_i = store_pending && (lu_if.page_offset_o[11:3] == store_off[11:3]);

  // memory side: automatic responder or manual drive
  logic resp_en = 1'b0;
  int   gnt_dly = 0;
  int   rv_dly = 0;
  logic resp_gnt = 1'b0, resp_rv = 1'b0;
  logic man_gnt = 1'b0, man_rv = 1'b0;
  int   rs = 0, rcnt = 0;
  assign lu_if.load_gnt_i    = resp_en ? resp_gnt : man_gnt;
  assign lu_if.load_rvalid_i = resp_en ? resp_rv  : man_rv;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n || !resp_en) begin
      rs = 0; rcnt = 0; resp_gnt = 1'b0; resp_rv = 1'b0;
    end else begin
      case (rs)
        0: if (lu_if.load_req_o) begin
             if (rcnt == gnt_dly) begin resp_gnt = 1'b1; rs = 1; rcnt = 0; end
             else rcnt++;
           end
        1: begin
             resp_gnt = 1'b0;
             if (rcnt == rv_dly) begin resp_rv = 1'b1; rs = 2; rcnt = 0; end
             else rcnt++;
           end
        default: begin resp_rv = 1'b0; rs = 0; rcnt = 0; end
      endcase
    end
  end

  // retire log
  int         done_cnt = 0;
  logic [7:0] done_pc_log [1024];
  int         done_cyc_log [1024];
  always @(negedge clk) begin
    if (rst_n && lu_if.load_done_o && done_cnt < 1024) begin
      done_pc_log[done_cnt]  = lu_if.load_done_pc_o;
      done_cyc_log[done_cnt] = cyc;
      done_cnt++;
    end
  end

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] pc_model = 8'h00;
  int         verified = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic enq(input logic [31:0] ins, output int ecyc, output int waits);
    waits = 0;
    lu_if.load_valid_i = 1'b1;
    lu_if.load_instr_i = ins;
    while (!lu_if.load_ready_o && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (!lu_if.load_ready_o) begin
      check("enq_ready_timeout", 32'd0, 32'd1);
      ecyc = -1;
    end else begin
      exp_q.push_back(pc_model);
      pc_model = pc_model + 8'd1;
      ecyc = cyc;
    end
    @(negedge clk);
    lu_if.load_valid_i = 1'b0;
  endtask

  task automatic wait_dones(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_count", done_cnt, target);
  endtask

  task automatic verify_dones();
    while (verified < done_cnt) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("done_pc", {24'h0, done_pc_log[verified]}, {24'h0, exp_q.pop_front()});
      verified++;
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    int          g;
    int          r;
    logic [11:0] exp_off;
    int          exp_lat;
  } vec_t;
  vec_t vecs [5];

  initial begin
    int ec, w, base, ecc, wc;
    vecs[0] = '{32'h0000_0123, 0, 0, 12'h123, 4};
    vecs[1] = '{32'hDEAD_BFFF, 1, 0, 12'hFFF, 5};
    vecs[2] = '{32'h1234_5000, 0, 2, 12'h000, 6};
    vecs[3] = '{32'hFFFF_F008, 3, 1, 12'h008, 8};
    vecs[4] = '{32'h0000_0ABC, 2, 2, 12'hABC, 8};

    lu_if.load_valid_i = 1'b0;
    lu_if.load_instr_i = 32'h0;

    // reset state
    @(negedge clk);
    check("rst_ready", lu_if.load_ready_o, 1);
    check("rst_req", lu_if.load_req_o, 0);
    check("rst_done", lu_if.load_done_o, 0);
    check("rst_offset", lu_if.page_offset_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // table: single loads with assorted grant/response delays
    resp_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      gnt_dly = vecs[i].g;
      rv_dly  = vecs[i].r;
      base = done_cnt;
      enq(vecs[i].instr, ec, w);
      check($sformatf("vec%0d_offset", i), lu_if.page_offset_o, vecs[i].exp_off);
      wait_dones(base + 1);
      verify_dones();
      check($sformatf("vec%0d_latency", i), done_cyc_log[base] - (ec + 1), vecs[i].exp_lat);
      check($sformatf("vec%0d_ready", i), lu_if.load_ready_o, 1);
      @(negedge clk);
    end

    // alias stall: five stall cycles in CHECK before the request
    gnt_dly = 0; rv_dly = 0;
    store_pending = 1'b1; store_off = 12'h128;
    base = done_cnt;
    enq(32'h0000_0128, ec, w);
    check("t3_offset", lu_if.page_offset_o, 12'h128);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t3_req_low%0d", i), lu_if.load_req_o, 0);
    end
`ifdef LU_STALL_CNT_EN
    check("t3_stall_cnt", stall_cnt, 5);
`endif
    store_pending = 1'b0;
    @(negedge clk);
    check("t3_req_high", lu_if.load_req_o, 1);
    wait_dones(base + 1);
    verify_dones();
    @(negedge clk);
    @(negedge clk);

    // spurious rvalid in CHECK/REQ and gnt in WAIT
    resp_en = 1'b0;
    store_pending = 1'b1; store_off = 12'h200;
    base = done_cnt;
    enq(32'h0000_0200, ec, w);
    @(negedge clk); man_rv = 1'b1;
    @(negedge clk); man_rv = 1'b0;
    check("t6_check_req", lu_if.load_req_o, 0);
    check("t6_check_done", lu_if.load_done_o, 0);
    @(negedge clk); store_pending = 1'b0;
    @(negedge clk);
    check("t6_req", lu_if.load_req_o, 1);
    man_rv = 1'b1;
    @(negedge clk); man_rv = 1'b0;
    check("t6_req_hold", lu_if.load_req_o, 1);
    check("t6_req_done", lu_if.load_done_o, 0);
    man_gnt = 1'b1;
    @(negedge clk); man_gnt = 1'b0;
    check("t6_wait_req", lu_if.load_req_o, 0);
    man_gnt = 1'b1;
    @(negedge clk); man_gnt = 1'b0;
    check("t6_wait_req_hold", lu_if.load_req_o, 0);
    check("t6_wait_done", lu_if.load_done_o, 0);
`ifdef LU_STALL_CNT_EN
    check("t6_stall_cnt", stall_cnt, 7);
`endif
    man_rv = 1'b1;
    @(negedge clk); man_rv = 1'b0;
    wait_dones(base + 1);
    verify_dones();
    check("t6_latency", done_cyc_log[base] - (ec + 1), 8);
    @(negedge clk);

    // reset in the middle of WAIT with a second load queued
    enq(32'h0000_0040, ec, w);
    enq(32'h0000_0080, ec, w);
    @(negedge clk);
    check("t1_req", lu_if.load_req_o, 1);
    man_gnt = 1'b1;
    @(negedge clk); man_gnt = 1'b0;
    check("t1_wait_req", lu_if.load_req_o, 0);
    check("t1_full_ready", lu_if.load_ready_o, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t1_req_rst", lu_if.load_req_o, 0);
    check("t1_done_rst", lu_if.load_done_o, 0);
    check("t1_ready_rst", lu_if.load_ready_o, 1);
    check("t1_offset_rst", lu_if.page_offset_o, 0);
    check("t1_donepc_rst", lu_if.load_done_pc_o, 0);
`ifdef LU_STALL_CNT_EN
    check("t1_stall_rst", stall_cnt, 0);
`endif
    exp_q.delete();
    pc_model = 8'h00;
    verified = done_cnt;
    rst_n = 1'b1;
    @(negedge clk);

    // back-pressure: third load waits for the first retire
    resp_en = 1'b1; gnt_dly = 0; rv_dly = 0;
    base = done_cnt;
    enq(32'h0000_0100, ec, w);
    enq(32'h0000_0208, ec, w);
    enq(32'h0000_0310, ecc, wc);
    wait_dones(base + 3);
    verify_dones();
    check("t4_third_waited", (wc > 0), 1);
    check("t4_third_enq_cycle", ecc, done_cyc_log[base]);
    check("t4_pc_last", {24'h0, done_pc_log[base + 2]}, 2);
    @(negedge clk);

    // wrap: 260 loads through the queue, tags wrap past 255
    base = done_cnt;
    for (int i = 0; i < 260; i++) begin
      enq($urandom, ec, w);
    end
    wait_dones(base + 260);
    verify_dones();
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_last_pc", {24'h0, done_pc_log[base + 259]}, 6);
    @(negedge clk);
    @(negedge clk);
    verify_dones();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
